// File: rtl/simpson_pkg.sv
// Shared encodings for the Simpson's-rule parameter entry controller.
package simpson_pkg;

    localparam int W_DEF  = 8;
    localparam int NW_DEF = 8;

    localparam logic [2:0] EDIT_A = 3'd0;
    localparam logic [2:0] EDIT_B = 3'd1;
    localparam logic [2:0] EDIT_N = 3'd2;
    localparam logic [2:0] REQ    = 3'd3;
    localparam logic [2:0] WAIT   = 3'd4;

    localparam logic [1:0] FIELD_A    = 2'd0;
    localparam logic [1:0] FIELD_B    = 2'd1;
    localparam logic [1:0] FIELD_N    = 2'd2;
    localparam logic [1:0] FIELD_NONE = 2'd3;

    function automatic logic [1:0] field_of(input logic [2:0] st);
        case (st)
            EDIT_A:  return FIELD_A;
            EDIT_B:  return FIELD_B;
            EDIT_N:  return FIELD_N;
            default: return FIELD_NONE;
        endcase
    endfunction

endpackage

// File: rtl/sat_updown_reg.sv
// Saturating up/down register; steps by STEP on a single-sided click and clamps to [MIN, MAX].
module sat_updown_reg #(
    parameter int WIDTH   = 8,
    parameter bit SIGNED  = 1'b1,
    parameter int STEP    = 1,
    parameter int MIN     = 0,
    parameter int MAX     = 255,
    parameter int RST_VAL = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             dec,
    input  logic             en,
    output logic [WIDTH-1:0] q
);

    // Two guard bits: enough headroom for signed overflow and for unsigned values near 2**WIDTH.
    localparam int XW = WIDTH + 2;
    localparam logic signed [XW-1:0] STEP_X = STEP[XW-1:0];
    localparam logic signed [XW-1:0] MIN_X  = MIN[XW-1:0];
    localparam logic signed [XW-1:0] MAX_X  = MAX[XW-1:0];

    logic signed [XW-1:0] q_x;
    logic signed [XW-1:0] sum_x;

    always_comb begin
        q_x = SIGNED ? {{2{q[WIDTH-1]}}, q} : {2'b00, q};
        sum_x = q_x;
        if (inc && !dec) begin
            sum_x = q_x + STEP_X;
        end else if (dec && !inc) begin
            sum_x = q_x - STEP_X;
        end
        if (sum_x > MAX_X) begin
            sum_x = MAX_X;
        end else if (sum_x < MIN_X) begin
            sum_x = MIN_X;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= RST_VAL[WIDTH-1:0];
        end else if (en) begin
            q <= sum_x[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/param_entry_fsm.sv
// Button-driven editor for integration bounds A/B and interval count N, with a start handshake to the core.
//  state  | meaning
//  EDIT_A | clicks adjust lower bound A
//  EDIT_B | clicks adjust upper bound B
//  EDIT_N | clicks adjust interval count N; next confirms
//  REQ    | parameters offered, waiting for start_ready
//  WAIT   | core running, waiting for calc_done
module param_entry_fsm
    import simpson_pkg::*;
#(
    parameter int W         = W_DEF,
    parameter int NW        = NW_DEF,
    parameter int N_MAX     = 254,
    parameter int B_DEFAULT = 1,
    parameter int STEP      = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          up_p,
    input  logic          down_p,
    input  logic          next_p,
    input  logic          start_ready,
    input  logic          calc_done,
    output logic [W-1:0]  a_out,
    output logic [W-1:0]  b_out,
    output logic [NW-1:0] n_out,
    output logic [1:0]    field_sel,
    output logic          start_valid,
    output logic          busy,
    output logic          err
);

    logic [2:0] state;
    logic [2:0] state_nxt;
    logic       a_lt_b;
    logic       editing;

    assign a_lt_b  = $signed(a_out) < $signed(b_out);
    assign editing = (state == EDIT_A) || (state == EDIT_B) || (state == EDIT_N);

    always_comb begin
        state_nxt = state;
        case (state)
            EDIT_A:  if (next_p) state_nxt = EDIT_B;
            EDIT_B:  if (next_p) state_nxt = EDIT_N;
            EDIT_N:  if (next_p) state_nxt = a_lt_b ? REQ : EDIT_A;
            REQ:     if (start_ready) state_nxt = WAIT;
            WAIT:    if (calc_done) state_nxt = EDIT_A;
            default: state_nxt = EDIT_A;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= EDIT_A;
            field_sel   <= FIELD_A;
            start_valid <= 1'b0;
            busy        <= 1'b0;
            err         <= 1'b0;
        end else begin
            state       <= state_nxt;
            field_sel   <= field_of(state_nxt);
            start_valid <= (state_nxt == REQ);
            busy        <= (state_nxt == REQ) || (state_nxt == WAIT);
            if (state == EDIT_N && next_p) begin
                err <= !a_lt_b;
            end else if (editing && !next_p && (up_p || down_p)) begin
                err <= 1'b0;
            end
        end
    end

    sat_updown_reg #(
        .WIDTH(W), .SIGNED(1'b1), .STEP(STEP),
        .MIN(-(2 ** (W - 1))), .MAX(2 ** (W - 1) - 1), .RST_VAL(0)
    ) u_a (
        .clk(clk), .rst_n(rst_n), .inc(up_p), .dec(down_p),
        .en((state == EDIT_A) && !next_p), .q(a_out)
    );

    sat_updown_reg #(
        .WIDTH(W), .SIGNED(1'b1), .STEP(STEP),
        .MIN(-(2 ** (W - 1))), .MAX(2 ** (W - 1) - 1), .RST_VAL(B_DEFAULT)
    ) u_b (
        .clk(clk), .rst_n(rst_n), .inc(up_p), .dec(down_p),
        .en((state == EDIT_B) && !next_p), .q(b_out)
    );

    sat_updown_reg #(
        .WIDTH(NW), .SIGNED(1'b0), .STEP(2),
        .MIN(2), .MAX(N_MAX), .RST_VAL(2)
    ) u_n (
        .clk(clk), .rst_n(rst_n), .inc(up_p), .dec(down_p),
        .en((state == EDIT_N) && !next_p), .q(n_out)
    );

endmodule
